// File: rtl/ifetch_pc.sv
// ifetch_pc: program counter and instruction-fetch stage feeding the control decoder.
// It fetches one 32-bit word per memory handshake and issues it for at least one cycle.
// It then advances the PC to pc+4, or to pc+branch_off when the issued branch is taken.
// Optional build macro: IFETCH_MISALIGN_TRAP_EN.
//   When it is defined, a taken branch to a target that is not word aligned raises
//   misalign and parks the FSM in HALT until the next reset.
//   When it is undefined, the two low target bits are cleared before loading pc.
module ifetch_pc #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch,
  input  logic        zero,
  input  logic [31:0] branch_off,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic        instr_valid
`ifdef IFETCH_MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_FETCH,
    S_ISSUE
`ifdef IFETCH_MISALIGN_TRAP_EN
    ,
    S_HALT
`endif
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_valid;
  logic        r_req;

  logic        w_taken;
  logic [31:0] w_target;
  logic [31:0] w_seq;
  logic [31:0] w_next;

  // Branch resolution is only meaningful in ISSUE, where branch/zero belong to the issued word.
  assign w_taken  = branch & zero;
  assign w_target = r_pc + branch_off;
  assign w_seq    = r_pc + 32'd4;

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic r_misalign;
  logic w_misalign;

  // A taken branch whose target is not word aligned traps instead of loading pc.
  assign w_misalign = w_taken & (w_target[1:0] != 2'b00);
  assign w_next     = w_taken ? w_target : w_seq;
  assign misalign   = r_misalign;
`else
  // Without the trap, the target is snapped down to a word boundary.
  assign w_next = w_taken ? (w_target & ~32'd3) : w_seq;
`endif

  // FSM with registered outputs: the sequence is BOOT -> FETCH (wait for ready) -> ISSUE (hold while stalled).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_BOOT;
      r_pc    <= RESET_PC;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
      r_req   <= 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
      r_misalign <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_BOOT: begin
          // The request goes out one cycle after reset, never in the first cycle.
          r_state <= S_FETCH;
          r_req   <= 1'b1;
        end
        S_FETCH: begin
          if (imem_ready) begin
            r_instr <= imem_rdata;
            r_valid <= 1'b1;
            r_req   <= 1'b0;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!stall) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
            if (w_misalign) begin
              r_misalign <= 1'b1;
              r_state    <= S_HALT;
            end else begin
              r_pc    <= w_next;
              r_req   <= 1'b1;
              r_state <= S_FETCH;
            end
`else
            r_pc    <= w_next;
            r_req   <= 1'b1;
            r_state <= S_FETCH;
`endif
          end
        end
`ifdef IFETCH_MISALIGN_TRAP_EN
        S_HALT: begin
          // HALT is parked until reset; nothing is requested or issued.
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
`endif
        default: begin
          r_state <= S_BOOT;
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instr       = r_instr;
  assign opcode      = r_instr[6:0];
  assign instr_valid = r_valid;

endmodule

// File: tb/tb_ifetch_pc.sv
// tb_ifetch_pc: randomized and directed bench for ifetch_pc with a transaction-level PC model.
module tb_ifetch_pc;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, branch, zero, stall, imem_ready;
  logic [31:0] branch_off, imem_rdata;
  logic        imem_req, instr_valid, req2, valid2;
  logic [31:0] imem_addr, pc, instr, addr2, pc2, instr2;
  logic [6:0]  opcode, opcode2;
`ifdef IFETCH_MISALIGN_TRAP_EN
  logic        misalign, misalign2;
`endif

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  ifetch_pc dut (
    .clk(clk), .rst(rst), .branch(branch), .zero(zero), .branch_off(branch_off),
    .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .pc(pc), .instr(instr), .opcode(opcode), .instr_valid(instr_valid)
`ifdef IFETCH_MISALIGN_TRAP_EN
    , .misalign(misalign)
`endif
  );

  ifetch_pc #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .branch(branch), .zero(zero), .branch_off(branch_off),
    .stall(stall), .imem_req(req2), .imem_addr(addr2), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .pc(pc2), .instr(instr2), .opcode(opcode2), .instr_valid(valid2)
`ifdef IFETCH_MISALIGN_TRAP_EN
    , .misalign(misalign2)
`endif
  );

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0033;
  endfunction

  // Architectural next-PC rule.
  function automatic logic [31:0] model_next(input logic [31:0] p, input logic t, input logic [31:0] off);
    logic [31:0] s;
    s = p + off;
    return t ? (s & 32'hFFFF_FFFC) : (p + 32'd4);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_ready = 1'b0; stall = 1'b0; branch = 1'b0; zero = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    exp_pc = 32'h0;
  endtask

  // One full instruction: fetch with 'waits' wait states, issue with 'stalls' stall cycles, then resolve.
  task automatic do_instr(input int waits, input int stalls, input logic br, input logic z, input logic [31:0] off);
    logic [31:0] w;
    int k;
    k = 0;
    while (imem_req !== 1'b1 && k < 5) begin tick(); k++; end
    n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL fetch_req_timeout req=%b want 1", imem_req); return; end
    n_chk++; if (imem_addr !== exp_pc) begin n_fail++; $display("FAIL fetch_addr got %h want %h", imem_addr, exp_pc); end
    for (int i = 0; i < waits; i++) begin
      imem_ready = 1'b0; imem_rdata = $urandom;
      tick();
      n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL wait_req got %b want 1", imem_req); end
      n_chk++; if (imem_addr !== exp_pc) begin n_fail++; $display("FAIL wait_addr got %h want %h", imem_addr, exp_pc); end
      n_chk++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL wait_valid got %b want 0", instr_valid); end
    end
    w = mem_word(exp_pc);
    imem_ready = 1'b1; imem_rdata = w;
    tick();
    imem_ready = 1'b0; imem_rdata = $urandom;
    n_chk++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL issue_valid got %b want 1", instr_valid); end
    n_chk++; if (instr !== w) begin n_fail++; $display("FAIL issue_instr got %h want %h", instr, w); end
    n_chk++; if (opcode !== w[6:0]) begin n_fail++; $display("FAIL issue_opcode got %h want %h", opcode, w[6:0]); end
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL issue_req got %b want 0", imem_req); end
    n_chk++; if (pc !== exp_pc) begin n_fail++; $display("FAIL issue_pc got %h want %h", pc, exp_pc); end
    branch = br; zero = z; branch_off = off;
    for (int i = 0; i < stalls; i++) begin
      stall = 1'b1;
      tick();
      n_chk++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid got %b want 1", instr_valid); end
      n_chk++; if (instr !== w) begin n_fail++; $display("FAIL stall_instr got %h want %h", instr, w); end
      n_chk++; if (pc !== exp_pc) begin n_fail++; $display("FAIL stall_pc got %h want %h", pc, exp_pc); end
    end
    stall = 1'b0;
    tick();
    branch = 1'b0; zero = 1'b0; branch_off = $urandom;
    exp_pc = model_next(exp_pc, br & z, off);
    n_chk++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL next_valid got %b want 0", instr_valid); end
    n_chk++; if (instr !== NOP) begin n_fail++; $display("FAIL next_instr got %h want %h", instr, NOP); end
    n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL next_req got %b want 1", imem_req); end
    n_chk++; if (imem_addr !== exp_pc) begin n_fail++; $display("FAIL next_addr got %h want %h", imem_addr, exp_pc); end
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h0000_0033;
    stall = 1'b0; branch = 1'b0; zero = 1'b0; branch_off = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if (pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc got %h want 0", pc); end
      n_chk++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_ctl valid=%b req=%b want 0 0", instr_valid, imem_req); end
      n_chk++; if (instr !== NOP || opcode !== 7'b0010011) begin n_fail++; $display("FAIL rst_instr got %h/%h want %h/13", instr, opcode, NOP); end
      n_chk++; if (pc2 !== 32'hFFFF_FFFC || instr2 !== NOP || opcode2 !== 7'h13 || valid2 !== 1'b0) begin n_fail++; $display("FAIL rst_wrap pc=%h instr=%h want fffffffc %h", pc2, instr2, NOP); end
`ifdef IFETCH_MISALIGN_TRAP_EN
      n_chk++; if (misalign !== 1'b0 || misalign2 !== 1'b0) begin n_fail++; $display("FAIL rst_misalign got %b want 0", misalign); end
`endif
    end
    rst = 1'b0;
    n_chk++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL boot_ctl req=%b valid=%b want 0 0", imem_req, instr_valid); end
    tick();
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL first_fetch req=%b addr=%h want 1 0", imem_req, imem_addr); end
    n_chk++; if (req2 !== 1'b1 || addr2 !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_fetch0 req=%b addr=%h want 1 fffffffc", req2, addr2); end
    tick();
    imem_ready = 1'b0;
    n_chk++; if (instr_valid !== 1'b1 || opcode !== 7'b0110011) begin n_fail++; $display("FAIL first_issue valid=%b opcode=%h want 1 33", instr_valid, opcode); end
    tick();
    n_chk++; if (imem_addr !== 32'h4 || imem_req !== 1'b1) begin n_fail++; $display("FAIL second_fetch addr=%h want 4", imem_addr); end
    n_chk++; if (req2 !== 1'b1 || addr2 !== 32'h0) begin n_fail++; $display("FAIL wrap_fetch1 addr=%h want 0", addr2); end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 0; i < 4; i++) do_instr(0, 0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_wait_stall();
    do_reset();
    do_instr(0, 0, 1'b0, 1'b0, 32'h0);
    do_instr(0, 0, 1'b0, 1'b0, 32'h0);
    do_instr(5, 3, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_branch();
    do_reset();
    for (int i = 0; i < 8; i++) do_instr(0, 0, 1'b0, 1'b0, 32'h0);
    do_instr(0, 0, 1'b1, 1'b1, 32'hFFFF_FFF0);
    n_chk++; if (imem_addr !== 32'h10) begin n_fail++; $display("FAIL branch_taken addr=%h want 10", imem_addr); end
    for (int i = 0; i < 4; i++) do_instr(0, 0, 1'b0, 1'b0, 32'h0);
    do_instr(0, 1, 1'b1, 1'b0, 32'hFFFF_FFF0);
    n_chk++; if (imem_addr !== 32'h24) begin n_fail++; $display("FAIL branch_not_taken addr=%h want 24", imem_addr); end
  endtask

  task automatic test_reset_midfetch();
    do_reset();
    do_instr(0, 0, 1'b0, 1'b0, 32'h0);
    imem_ready = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL midfetch_req_drop got %b want 0", imem_req); end
    imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    n_chk++; if (instr !== NOP || instr_valid !== 1'b0 || pc !== 32'h0) begin n_fail++; $display("FAIL midfetch_rst instr=%h valid=%b pc=%h want %h 0 0", instr, instr_valid, pc, NOP); end
    rst = 1'b0;
    n_chk++; if (imem_req !== 1'b0 || instr !== NOP) begin n_fail++; $display("FAIL midfetch_boot req=%b instr=%h want 0 %h", imem_req, instr, NOP); end
    tick();
    imem_ready = 1'b0;
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr !== NOP) begin n_fail++; $display("FAIL midfetch_refetch req=%b addr=%h want 1 0", imem_req, imem_addr); end
    exp_pc = 32'h0;
    do_instr(1, 0, 1'b0, 1'b0, 32'h0);
    // Reset during a stalled issue must win over the stall.
    imem_ready = 1'b1; imem_rdata = mem_word(exp_pc);
    tick();
    imem_ready = 1'b0; stall = 1'b1; rst = 1'b1;
    tick();
    n_chk++; if (pc !== 32'h0 || instr_valid !== 1'b0 || instr !== NOP) begin n_fail++; $display("FAIL rst_in_issue pc=%h valid=%b want 0 0", pc, instr_valid); end
    stall = 1'b0; rst = 1'b0;
    tick();
  endtask

  task automatic test_misalign();
    do_reset();
`ifdef IFETCH_MISALIGN_TRAP_EN
    imem_ready = 1'b1; imem_rdata = mem_word(32'h0);
    tick();
    imem_ready = 1'b0;
    branch = 1'b1; zero = 1'b1; branch_off = 32'h6; stall = 1'b0;
    tick();
    branch = 1'b0; zero = 1'b0;
    n_chk++; if (misalign !== 1'b1) begin n_fail++; $display("FAIL misalign_flag got %b want 1", misalign); end
    n_chk++; if (instr_valid !== 1'b0 || pc !== 32'h0) begin n_fail++; $display("FAIL misalign_state valid=%b pc=%h want 0 0", instr_valid, pc); end
    imem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++; if (imem_req !== 1'b0 || misalign !== 1'b1 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL halt_hold req=%b misalign=%b want 0 1", imem_req, misalign); end
    end
    do_reset();
    n_chk++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL misalign_clear got %b want 0", misalign); end
`else
    do_instr(0, 0, 1'b1, 1'b1, 32'h6);
    n_chk++; if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL misalign_snap addr=%h want 4", imem_addr); end
`endif
  endtask

  task automatic test_random();
    logic [31:0] r, off;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      r = $urandom;
      off = {{20{r[11]}}, r[11:0]};
`ifdef IFETCH_MISALIGN_TRAP_EN
      off = off & 32'hFFFF_FFFC;
`else
      off = off & 32'hFFFF_FFFE;
`endif
      do_instr($urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), off);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wait_stall();
    test_branch();
    test_reset_midfetch();
    test_misalign();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
